// File: rtl/styler_seq.sv
// Character-cell styler sequencer: walks a text frame cell by cell, fetches one glyph
// scanline per cell and presents it to the styler together with frame-level phase bits.
module styler_seq #(
  parameter int COLS       = 80,
  parameter int ROWS       = 25,
  parameter int BLINK_BIT  = 5,
  parameter int CURSOR_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frameStart,
  input  logic [6:0]  cursorCol,
  input  logic [5:0]  cursorRow,
  output logic        fetchReq,
  output logic [6:0]  fetchCol,
  output logic [5:0]  fetchRow,
  input  logic        fetchAck,
  input  logic [15:0] fetchBitmap,
  output logic        outValid,
  input  logic        outReady,
  output logic [15:0] bitmapOut,
  output logic [3:0]  scanlineOut,
  output logic [6:0]  colOut,
  output logic        cursorEnable,
  output logic        faintPhase,
  output logic        blinkPhase,
  output logic        cursorPhase,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for frameStart
  // FETCH | fetchReq raised for (col,row), waiting for fetchAck
  // EMIT  | slice presented with outValid, waiting for outReady

  typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

  localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0] LAST_ROW  = 6'(ROWS - 1);
  localparam logic [3:0] LAST_SCAN = 4'd15;

  state_t     state, stateNext;
  logic [6:0] col, colNext;
  logic [3:0] scan, scanNext;
  logic [5:0] row, rowNext;
  logic [7:0] frameCount;
  logic       captureSlice;
  logic       frameEnd;

  always_comb begin
    stateNext    = state;
    colNext      = col;
    scanNext     = scan;
    rowNext      = row;
    captureSlice = 1'b0;
    frameEnd     = 1'b0;
    case (state)
      IDLE: begin
        if (frameStart) begin
          colNext   = '0;
          scanNext  = '0;
          rowNext   = '0;
          stateNext = FETCH;
        end
      end
      FETCH: begin
        if (fetchAck) begin
          captureSlice = 1'b1;
          stateNext    = EMIT;
        end
      end
      EMIT: begin
        if (outReady) begin
          stateNext = FETCH;
          if (col < LAST_COL) begin
            colNext = col + 7'd1;
          end else begin
            colNext  = '0;
            scanNext = scan + 4'd1;
            // scan wraps to 0 on its own after the last scanline of a row
            if (scan == LAST_SCAN) begin
              if (row < LAST_ROW) begin
                rowNext = row + 6'd1;
              end else begin
                rowNext   = '0;
                stateNext = IDLE;
                frameEnd  = 1'b1;
              end
            end
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      scan         <= '0;
      row          <= '0;
      frameCount   <= '0;
      faintPhase   <= 1'b0;
      bitmapOut    <= '0;
      scanlineOut  <= '0;
      colOut       <= '0;
      cursorEnable <= 1'b0;
    end else begin
      state <= stateNext;
      col   <= colNext;
      scan  <= scanNext;
      row   <= rowNext;
      // cursor position is sampled only here, so mid-cell moves wait for the next cell
      if (captureSlice) begin
        bitmapOut    <= fetchBitmap;
        scanlineOut  <= scan;
        colOut       <= col;
        cursorEnable <= (col == cursorCol) && (row == cursorRow);
      end
      if (frameEnd) begin
        frameCount <= frameCount + 8'd1;
        faintPhase <= ~faintPhase;
      end
    end
  end

  assign fetchReq    = (state == FETCH);
  assign outValid    = (state == EMIT);
  assign busy        = (state != IDLE);
  assign fetchCol    = col;
  assign fetchRow    = row;
  assign blinkPhase  = frameCount[BLINK_BIT];
  assign cursorPhase = frameCount[CURSOR_BIT];

endmodule

// File: tb/tb_styler_seq.sv
// Scoreboard bench for styler_seq: a driver predicts each slice from the frame's
// cell order and pushes it into a queue; a monitor pops and compares on every slice transfer.
module tb_styler_seq;
  localparam int COLS       = 3;
  localparam int ROWS       = 2;
  localparam int BLINK_BIT  = 5;
  localparam int CURSOR_BIT = 4;
  localparam int SLICES     = COLS * 16 * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frameStart = 1'b0;
  logic [6:0]  cursorCol = '0;
  logic [5:0]  cursorRow = '0;
  logic        fetchReq;
  logic [6:0]  fetchCol;
  logic [5:0]  fetchRow;
  logic        fetchAck = 1'b0;
  logic [15:0] fetchBitmap = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [15:0] bitmapOut;
  logic [3:0]  scanlineOut;
  logic [6:0]  colOut;
  logic        cursorEnable;
  logic        faintPhase;
  logic        blinkPhase;
  logic        cursorPhase;
  logic        busy;

  always #5 clk = ~clk;

  styler_seq #(.COLS(COLS), .ROWS(ROWS), .BLINK_BIT(BLINK_BIT), .CURSOR_BIT(CURSOR_BIT)) dut (
    .clk(clk), .rst(rst), .frameStart(frameStart),
    .cursorCol(cursorCol), .cursorRow(cursorRow),
    .fetchReq(fetchReq), .fetchCol(fetchCol), .fetchRow(fetchRow),
    .fetchAck(fetchAck), .fetchBitmap(fetchBitmap),
    .outValid(outValid), .outReady(outReady),
    .bitmapOut(bitmapOut), .scanlineOut(scanlineOut), .colOut(colOut),
    .cursorEnable(cursorEnable), .faintPhase(faintPhase),
    .blinkPhase(blinkPhase), .cursorPhase(cursorPhase), .busy(busy)
  );

  typedef struct { int col; int row; int scan; bit last; } pos_t;
  typedef struct { logic [15:0] bmp; int scan; int col; bit cur; bit last; } slice_t;

  pos_t   posQ[$];
  slice_t expQ[$];
  int     checks = 0;
  int     errors = 0;
  bit     frameOpen = 1'b0;
  bit     monOn = 1'b0;
  bit     flushReq = 1'b0;
  int     frames = 0;
  int     waitCnt = 0;
  int     stallCnt = 0;
  int     expFrames = 0;
  bit     expBusy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_fetchReq", int'(fetchReq), 0);
    chk("rst_outValid", int'(outValid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cursorEnable", int'(cursorEnable), 0);
    chk("rst_bitmapOut", int'(bitmapOut), 0);
    chk("rst_scanlineOut", int'(scanlineOut), 0);
    chk("rst_colOut", int'(colOut), 0);
    chk("rst_fetchCol", int'(fetchCol), 0);
    chk("rst_fetchRow", int'(fetchRow), 0);
    chk("rst_faintPhase", int'(faintPhase), 0);
    chk("rst_blinkPhase", int'(blinkPhase), 0);
    chk("rst_cursorPhase", int'(cursorPhase), 0);
  endtask

  // One cycle of stimulus, called just after a falling edge.
  task automatic drive_body(input bit fast, input bit allowStart);
    pos_t   p;
    slice_t s;
    if (frameOpen) frameStart = ($urandom_range(0, 9) == 0);
    else           frameStart = allowStart && (fast || ($urandom_range(0, 3) == 0));
    if (frameStart && !frameOpen) begin
      for (int r = 0; r < ROWS; r++)
        for (int sc = 0; sc < 16; sc++)
          for (int c = 0; c < COLS; c++) begin
            p.col = c; p.row = r; p.scan = sc;
            p.last = (r == ROWS - 1) && (sc == 15) && (c == COLS - 1);
            posQ.push_back(p);
          end
      frameOpen = 1'b1;
    end

    if ($urandom_range(0, 3) == 0) begin
      cursorCol = 7'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, COLS));
      cursorRow = 6'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, ROWS));
    end

    if (fetchReq) begin
      if (posQ.size() == 0) begin
        chk("fetch_unexpected", 1, 0);
        fetchAck = 1'b0;
      end else begin
        chk("fetchCol", int'(fetchCol), posQ[0].col);
        chk("fetchRow", int'(fetchRow), posQ[0].row);
        if (waitCnt == 0) begin
          p = posQ.pop_front();
          fetchAck = 1'b1;
          fetchBitmap = ($urandom_range(0, 7) == 0) ? 16'hA5C3 : 16'($urandom);
          s.bmp = fetchBitmap;
          s.scan = p.scan;
          s.col = p.col;
          s.cur = (p.col == int'(cursorCol)) && (p.row == int'(cursorRow));
          s.last = p.last;
          expQ.push_back(s);
          waitCnt = fast ? 0 : int'($urandom_range(0, 4));
        end else begin
          fetchAck = 1'b0;
          fetchBitmap = 16'($urandom);
          waitCnt--;
        end
      end
    end else begin
      fetchAck = fast || ($urandom_range(0, 3) == 0);
      fetchBitmap = 16'($urandom);
    end

    if (fast) outReady = 1'b1;
    else if (stallCnt > 0) begin
      outReady = 1'b0;
      stallCnt--;
    end else if ($urandom_range(0, 3) == 0) begin
      outReady = 1'b0;
      stallCnt = int'($urandom_range(0, 5));
    end else outReady = 1'b1;
  endtask

  // Monitor: compares every EMIT cycle against the queue head, pops on transfer.
  initial begin
    slice_t s;
    forever begin
      @(negedge clk);
      #1;
      if (!monOn) continue;
      if (flushReq) begin
        expQ.delete();
        frameOpen = 1'b0;
        frames = 0;
        expFrames = 0;
        expBusy = 1'b0;
        flushReq = 1'b0;
        continue;
      end
      chk("busy", int'(busy), int'(expBusy));
      chk("faintPhase", int'(faintPhase), expFrames % 2);
      chk("blinkPhase", int'(blinkPhase), ((expFrames % 256) >> BLINK_BIT) % 2);
      chk("cursorPhase", int'(cursorPhase), ((expFrames % 256) >> CURSOR_BIT) % 2);
      chk("valid_and_req", int'(fetchReq && outValid), 0);
      if (outValid) begin
        if (expQ.size() == 0) chk("slice_unexpected", 1, 0);
        else begin
          s = expQ[0];
          chk("bitmapOut", int'(bitmapOut), int'(s.bmp));
          chk("scanlineOut", int'(scanlineOut), s.scan);
          chk("colOut", int'(colOut), s.col);
          chk("cursorEnable", int'(cursorEnable), int'(s.cur));
          if (outReady) begin
            void'(expQ.pop_front());
            if (s.last) begin
              frames++;
              frameOpen = 1'b0;
            end
          end
        end
      end
      expFrames = frames;
      expBusy = frameOpen;
    end
  end

  initial begin
    int f0;
    int n;
    int guard;

    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    monOn = 1'b1;

    // Back-to-back frame: ack and ready held high, two cycles per slice.
    f0 = frames;
    n = 0;
    guard = 0;
    @(negedge clk);
    drive_body(1'b1, 1'b1);
    while (frames == f0 && guard < 1000) begin
      @(negedge clk);
      drive_body(1'b1, 1'b0);
      if (busy) n++;
      guard++;
    end
    chk("fast_busy_cycles", n, 2 * SLICES);
    chk("fast_frames", frames, f0 + 1);

    // Random handshakes across enough frames to roll the blink bit.
    guard = 0;
    while (frames < 33 && guard < 60000) begin
      @(negedge clk);
      drive_body(1'b0, 1'b1);
      guard++;
    end
    chk("frames_done", frames, 33);

    // Reset while a slice is being presented.
    guard = 0;
    @(negedge clk);
    while (!(outValid && frameOpen && posQ.size() < SLICES - 4) && guard < 5000) begin
      drive_body(1'b0, 1'b1);
      @(negedge clk);
      guard++;
    end
    chk("emit_before_reset", int'(outValid), 1);
    rst = 1'b1;
    outReady = 1'b0;
    fetchAck = 1'b0;
    frameStart = 1'b0;
    posQ.delete();
    waitCnt = 0;
    stallCnt = 0;
    flushReq = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    fetchAck = 1'b1;
    fetchBitmap = 16'hFFFF;

    guard = 0;
    while (frames < 1 && guard < 10000) begin
      @(negedge clk);
      drive_body(1'b0, 1'b1);
      guard++;
    end
    chk("post_reset_frame", frames, 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
